// File: rtl/opcode_fifo_if.sv
// Word-in and opcode-out handshake bundle for the opcode assembly FIFO.
interface opcode_fifo_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [95:0] opcode;
    logic        op_valid;
    logic        op_ready;

    // Producer of words / consumer of opcodes
    modport master (
        output word_in,
        output word_valid,
        output op_ready,
        input  word_ready,
        input  opcode,
        input  op_valid
    );

    // The assembler/FIFO itself
    modport slave (
        input  word_in,
        input  word_valid,
        input  op_ready,
        output word_ready,
        output opcode,
        output op_valid
    );
endinterface

// File: rtl/opcode_fifo.sv
// Assembles groups of three 32-bit command words into 96-bit opcodes and
// buffers whole opcodes in a first-word-fall-through FIFO for the decoder.
module opcode_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    opcode_fifo_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         partial
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = 32;
    localparam int unsigned OW = 96;

    localparam logic [1:0] W0 = 2'd0;
    localparam logic [1:0] W1 = 2'd1;
    localparam logic [1:0] W2 = 2'd2;

    logic [1:0]    phase;
    logic [1:0]    phase_nxt;
    logic [WW-1:0] stage0;
    logic [WW-1:0] stage1;
    logic [OW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic op_valid_c;
    logic word_ready_c;
    logic accept;
    logic push;
    logic pop;

    // Handshake qualifiers; a pop during clear is dropped since the FIFO empties anyway
    assign op_valid_c   = (count != '0);
    assign word_ready_c = ~clear & ((phase != W2) | (count < CW'(DEPTH)) |
                                    (op_valid_c & bus.op_ready));
    assign accept       = bus.word_valid & word_ready_c;
    assign push         = accept & (phase == W2);
    assign pop          = op_valid_c & bus.op_ready & ~clear;

    assign bus.word_ready = word_ready_c;
    assign bus.op_valid   = op_valid_c;
    assign bus.opcode     = op_valid_c ? mem[rd_ptr] : '0;
    assign partial        = (phase != W0);

    // Assembler phase register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= W0;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Assembler next phase: advance one word slot per accepted word
    always_comb begin
        phase_nxt = phase;
        if (accept) begin
            case (phase)
                W0:      phase_nxt = W1;
                W1:      phase_nxt = W2;
                default: phase_nxt = W0;
            endcase
        end
    end

    // Staging of the first two words of an opcode
    always_ff @(posedge clk) begin
        if (accept && (phase == W0)) begin
            stage0 <= bus.word_in;
        end
        if (accept && (phase == W1)) begin
            stage1 <= bus.word_in;
        end
    end

    // FIFO storage; the third word goes straight into the tail entry
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {stage0, stage1, bus.word_in};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_opcode_fifo.sv
// Directed and randomized back-pressure bench for opcode_fifo.
module tb_opcode_fifo;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [2:0] count;
    logic       partial;

    int compared   = 0;
    int mismatched = 0;

    opcode_fifo_if bus();

    opcode_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .bus     (bus),
        .count   (count),
        .partial (partial)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) until it is taken
    task automatic send(input logic [31:0] w);
        bit done;
        done = 1'b0;
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            done = bus.word_ready;
            tick();
        end
        bus.word_valid = 1'b0;
        chk("send_accepted", 96'(done), 96'd1);
    endtask

    // Consume the head opcode, checking it first
    task automatic pop_chk(input string tag, input logic [95:0] exp);
        bus.op_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, 96'(bus.op_valid), 96'd1);
        chk(tag, bus.opcode, exp);
        tick();
        bus.op_ready = 1'b0;
    endtask

    function automatic logic [95:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
        return {a, b, c};
    endfunction

    logic [95:0] exp_op [6];
    logic [95:0] expq [$];
    logic [31:0] grp [3];
    int          gi;
    int          sent_words;
    int          popped;
    int          cyc;

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        bus.word_in    = '0;
        bus.word_valid = 1'b0;
        bus.op_ready   = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_count", 96'(count), 96'd0);
        chk("rst_op_valid", 96'(bus.op_valid), 96'd0);
        chk("rst_opcode", bus.opcode, 96'd0);
        chk("rst_partial", 96'(partial), 96'd0);
        rst = 1'b0;
        #1;
        chk("rst_word_ready", 96'(bus.word_ready), 96'd1);

        // First opcode, no consumer
        send(32'h1234_0001);
        send(32'hAAAA_BBBB);
        send(32'hCCCC_DDDD);
        exp_op[1] = 96'h1234_0001_AAAA_BBBB_CCCC_DDDD;
        chk("t1_op_valid", 96'(bus.op_valid), 96'd1);
        chk("t1_opcode", bus.opcode, exp_op[1]);
        chk("t1_count", 96'(count), 96'd1);
        chk("t1_partial", 96'(partial), 96'd0);

        // Fill to DEPTH opcodes, then stage two more words
        for (int k = 2; k <= 4; k++) begin
            exp_op[k] = mk(32'hA000_0000 | 32'(k), 32'hB000_0000 | 32'(k),
                           32'hC000_0000 | 32'(k));
            send(exp_op[k][95:64]);
            send(exp_op[k][63:32]);
            send(exp_op[k][31:0]);
        end
        chk("t2_count_full", 96'(count), 96'd4);
        exp_op[5] = mk(32'hD000_0013, 32'hD000_0014, 32'hD000_0015);
        send(exp_op[5][95:64]);
        send(exp_op[5][63:32]);
        chk("t2_partial", 96'(partial), 96'd1);
        bus.word_in    = exp_op[5][31:0];
        bus.word_valid = 1'b1;
        #1;
        chk("t2_w2_stall", 96'(bus.word_ready), 96'd0);
        tick();
        chk("t2_count_hold", 96'(count), 96'd4);
        chk("t2_partial_hold", 96'(partial), 96'd1);
        chk("t2_head_stable", bus.opcode, exp_op[1]);

        // Full + pop + push in the same cycle
        bus.op_ready = 1'b1;
        #1;
        chk("t3_ready_on_pop", 96'(bus.word_ready), 96'd1);
        tick();
        bus.op_ready   = 1'b0;
        bus.word_valid = 1'b0;
        chk("t3_count", 96'(count), 96'd4);
        chk("t3_partial", 96'(partial), 96'd0);
        for (int k = 2; k <= 5; k++) begin
            pop_chk($sformatf("t3_head%0d", k), exp_op[k]);
            chk($sformatf("t3_count%0d", k), 96'(count), 96'(5 - k));
        end
        chk("t3_empty_valid", 96'(bus.op_valid), 96'd0);
        chk("t3_empty_opcode", bus.opcode, 96'd0);

        // Reset in the middle of an opcode, with traffic present
        send(32'h5555_0001);
        send(32'h5555_0002);
        chk("t4_partial_pre", 96'(partial), 96'd1);
        bus.word_in    = 32'hDEAD_BEEF;
        bus.word_valid = 1'b1;
        bus.op_ready   = 1'b1;
        rst            = 1'b1;
        tick();
        rst            = 1'b0;
        bus.word_valid = 1'b0;
        bus.op_ready   = 1'b0;
        chk("t4_partial", 96'(partial), 96'd0);
        chk("t4_count", 96'(count), 96'd0);
        chk("t4_op_valid", 96'(bus.op_valid), 96'd0);
        #1;
        chk("t4_word_ready", 96'(bus.word_ready), 96'd1);
        send(32'hE000_0001);
        send(32'hE000_0002);
        send(32'hE000_0003);
        chk("t4_count1", 96'(count), 96'd1);
        pop_chk("t4_fresh", mk(32'hE000_0001, 32'hE000_0002, 32'hE000_0003));

        // Clear with two stored opcodes and one staged word
        for (int k = 0; k < 6; k++) begin
            send(32'hF000_0000 | 32'(k));
        end
        send(32'h7777_0001);
        chk("t5_count_pre", 96'(count), 96'd2);
        chk("t5_partial_pre", 96'(partial), 96'd1);
        bus.word_in    = 32'h7777_0002;
        bus.word_valid = 1'b1;
        bus.op_ready   = 1'b1;
        clear          = 1'b1;
        #1;
        chk("t5_clear_stall", 96'(bus.word_ready), 96'd0);
        tick();
        clear          = 1'b0;
        bus.word_valid = 1'b0;
        bus.op_ready   = 1'b0;
        chk("t5_count", 96'(count), 96'd0);
        chk("t5_op_valid", 96'(bus.op_valid), 96'd0);
        chk("t5_partial", 96'(partial), 96'd0);
        chk("t5_opcode", bus.opcode, 96'd0);
        send(32'h9000_0001);
        send(32'h9000_0002);
        send(32'h9000_0003);
        pop_chk("t5_fresh", mk(32'h9000_0001, 32'h9000_0002, 32'h9000_0003));

        // Random back-pressure on both sides against a queue model
        gi         = 0;
        sent_words = 0;
        popped     = 0;
        cyc        = 0;
        while (popped < 200 && cyc < 20000) begin
            bus.word_valid = (sent_words < 600) && ($urandom_range(0, 99) < 60);
            bus.word_in    = $urandom;
            bus.op_ready   = ($urandom_range(0, 99) < 50);
            #1;
            chk("rand_count", 96'(count), 96'(expq.size()));
            chk("rand_le_depth", 96'(count <= 3'(DEPTH)), 96'd1);
            if (bus.op_valid && bus.op_ready) begin
                if (expq.size() != 0) begin
                    chk("rand_data", bus.opcode, expq.pop_front());
                    popped++;
                end else begin
                    chk("rand_underflow", 96'(bus.op_valid), 96'd0);
                end
            end
            if (bus.word_valid && bus.word_ready) begin
                grp[gi] = bus.word_in;
                gi++;
                sent_words++;
                if (gi == 3) begin
                    expq.push_back(mk(grp[0], grp[1], grp[2]));
                    gi = 0;
                end
            end
            tick();
            cyc++;
        end
        bus.word_valid = 1'b0;
        bus.op_ready   = 1'b0;
        chk("rand_popped", 96'(popped), 96'd200);
        chk("rand_model_drained", 96'(expq.size()), 96'd0);
        chk("rand_final_count", 96'(count), 96'd0);
        chk("rand_final_partial", 96'(partial), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
